// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with tagged one-cycle responses.
// Define ALU_ARB_ILLEGAL_CHK_EN to answer function codes >= NUM_FUNS with an error response instead of issuing them.
module alu_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int ALU_LAT    = 1,
  parameter int NUM_FUNS   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0_Valid,
  input  logic [DATA_WIDTH-1:0] Req0_A,
  input  logic [DATA_WIDTH-1:0] Req0_B,
  input  logic [FUN_WIDTH-1:0]  Req0_Fun,
  output logic                  Req0_Ready,
  input  logic                  Req1_Valid,
  input  logic [DATA_WIDTH-1:0] Req1_A,
  input  logic [DATA_WIDTH-1:0] Req1_B,
  input  logic [FUN_WIDTH-1:0]  Req1_Fun,
  output logic                  Req1_Ready,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  output logic                  Rsp_Valid,
  output logic                  Rsp_Id,
  output logic [DATA_WIDTH-1:0] Rsp_Data,
  output logic                  Rsp_Err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  if (ALU_LAT < 1 || ALU_LAT > 15 || NUM_FUNS < 1 || NUM_FUNS > (1 << FUN_WIDTH)) begin : g_bad_cfg
    $error("alu_arbiter: illegal parameter set");
  end

  logic [1:0]            state_q, state_d;
  logic                  ptr_q, ptr_d, id_q, id_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic                  rsp_v_q, rsp_v_d, rsp_id_q, rsp_id_d, err_q, err_d;
  logic                  gnt0, gnt1, sel, ill;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [FUN_WIDTH-1:0]  sel_fun;

  // both valid: the pointer decides; it flips to the loser on every grant
  assign gnt0    = RST && state_q == IDLE && Req0_Valid && (!Req1_Valid || !ptr_q);
  assign gnt1    = RST && state_q == IDLE && Req1_Valid && (!Req0_Valid || ptr_q);
  assign sel     = gnt1;
  assign sel_a   = sel ? Req1_A : Req0_A;
  assign sel_b   = sel ? Req1_B : Req0_B;
  assign sel_fun = sel ? Req1_Fun : Req0_Fun;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign ill = 32'(sel_fun) >= NUM_FUNS;
`else
  assign ill = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    fun_d    = fun_q;
    rsp_v_d  = 1'b0;
    rsp_id_d = rsp_id_q;
    data_d   = data_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (gnt0 || gnt1) begin
        ptr_d = !sel;
        if (ill) begin
          rsp_v_d  = 1'b1;
          rsp_id_d = sel;
          data_d   = '0;
          err_d    = 1'b1;
        end else begin
          a_d     = sel_a;
          b_d     = sel_b;
          fun_d   = sel_fun;
          id_d    = sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 4'(ALU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          rsp_v_d  = 1'b1;
          rsp_id_d = id_q;
          data_d   = ALU_OUT;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fun_q    <= fun_d;
      rsp_v_q  <= rsp_v_d;
      rsp_id_q <= rsp_id_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  assign Req0_Ready = gnt0;
  assign Req1_Ready = gnt1;
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;
  assign ALU_FUN    = fun_q;
  assign ALU_EN     = state_q == ISSUE;
  assign Rsp_Valid  = rsp_v_q;
  assign Rsp_Id     = rsp_id_q;
  assign Rsp_Data   = data_q;
  assign Rsp_Err    = err_q;
endmodule
